// File: rtl/serial_rx_pkg.sv
//==============================================================================
// Module   : serial_rx_pkg
// Purpose  : Shared types and constants for the serial frame receiver.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    function automatic int bit_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_shift_in.sv
//==============================================================================
// Module   : serial_shift_in
// Purpose  : Serial-in/parallel-out register, MSB first, with running parity.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_shift_in #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_data,
    output logic             o_parity
);

    logic [WIDTH-1:0] r_data;
    logic             r_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_parity <= 1'b0;
        end else if (i_clr) begin
            r_data   <= '0;
            r_parity <= 1'b0;
        end else if (i_en) begin
            r_data   <= {r_data[WIDTH-2:0], i_bit};
            r_parity <= r_parity ^ i_bit;
        end
    end

    assign o_data   = r_data;
    assign o_parity = r_parity;

endmodule

`default_nettype wire

// File: rtl/serial_frame_receiver.sv
//==============================================================================
// Module   : serial_frame_receiver
// Purpose  : Framed serial byte receiver with parity/framing checks and counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_frame_receiver
    import serial_rx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1,
    parameter bit ODD       = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SI,
    output logic [WIDTH-1:0] PO,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy,
    output logic [7:0]       count
);

    localparam int CW = bit_cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_par_fail;
    logic [WIDTH-1:0] w_data;
    logic             w_parity;
    logic             w_clr;
    logic             w_shift_en;
    logic             w_set_pfail;
    logic             w_load;
    logic             w_perr_n;
    logic             w_ferr_n;

    serial_shift_in #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_shift_en),
        .i_bit   (SI),
        .o_data  (w_data),
        .o_parity(w_parity)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_clr       = 1'b0;
        w_shift_en  = 1'b0;
        w_set_pfail = 1'b0;
        w_load      = 1'b0;
        w_perr_n    = 1'b0;
        w_ferr_n    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (SI != IDLE_LEVEL) begin
                    w_clr  = 1'b1;
                    w_next = DATA;
                end
            end
            DATA: begin
                w_shift_en = 1'b1;
                if (r_bit_cnt == CW'(WIDTH - 1))
                    w_next = PARITY_EN ? PARITY : STOP;
            end
            PARITY: begin
                // Parity bit closes the running XOR; a good frame lands on ODD.
                w_set_pfail = ((w_parity ^ SI) != ODD);
                w_next      = STOP;
            end
            STOP: begin
                if (SI == IDLE_LEVEL) begin
                    w_load   = ~r_par_fail;
                    w_perr_n = r_par_fail;
                    w_next   = IDLE;
                end else begin
                    w_ferr_n = 1'b1;
                    w_perr_n = r_par_fail;
                    w_next   = BREAK;
                end
            end
            BREAK: begin
                if (SI == IDLE_LEVEL) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_par_fail <= 1'b0;
            PO         <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            count      <= 8'd0;
        end else begin
            valid      <= w_load;
            parity_err <= w_perr_n;
            frame_err  <= w_ferr_n;
            if (w_clr) begin
                r_bit_cnt  <= '0;
                r_par_fail <= 1'b0;
            end else begin
                if (w_shift_en)  r_bit_cnt  <= r_bit_cnt + CW'(1);
                if (w_set_pfail) r_par_fail <= 1'b1;
            end
            if (w_load) begin
                PO    <= w_data;
                count <= count + 8'd1;
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
//==============================================================================
// Module   : tb_serial_frame_receiver
// Purpose  : Directed self-checking bench for serial_frame_receiver.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_frame_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SI  = 1'b1;
    logic [7:0] PO;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int v_last   = -1;
    int v_prev   = -1;

    serial_frame_receiver #(
        .WIDTH    (8),
        .PARITY_EN(1'b1),
        .ODD      (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SI        (SI),
        .PO        (PO),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy),
        .count     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            v_prev = v_last;
            v_last = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one bit, let the next rising edge sample it, settle 1 time unit.
    task automatic send_bit(input logic b);
        SI = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
    endtask

    task automatic check_flags(input string tag, input logic v, input logic pe, input logic fe);
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
        check({tag, ".perr"},  {31'd0, parity_err}, {31'd0, pe});
        check({tag, ".ferr"},  {31'd0, frame_err}, {31'd0, fe});
    endtask

    initial begin
        // Reset state
        #1;
        check("rst.PO", {24'd0, PO}, 32'h00);
        check("rst.count", {24'd0, count}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send_bit(1'b1);

        // Good 0xA5, even parity 0
        send_bit(1'b0);
        check("a5.busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 7; i >= 0; i--) send_bit(8'hA5 >> i);
        send_bit(1'b0);
        check_flags("a5.pre_stop", 1'b0, 1'b0, 1'b0);
        send_bit(1'b1);
        check_flags("a5", 1'b1, 1'b0, 1'b0);
        check("a5.PO", {24'd0, PO}, 32'hA5);
        check("a5.count", {24'd0, count}, 32'd1);
        check("a5.busy", {31'd0, busy}, 32'd0);
        send_bit(1'b1);
        check_flags("a5.after", 1'b0, 1'b0, 1'b0);

        // Parity error: 0x01 with parity 0
        send_frame(8'h01, 1'b0, 1'b1);
        check_flags("perr", 1'b0, 1'b1, 1'b0);
        check("perr.PO", {24'd0, PO}, 32'hA5);
        check("perr.count", {24'd0, count}, 32'd1);
        send_bit(1'b1);
        check_flags("perr.after", 1'b0, 1'b0, 1'b0);

        // Framing error then line held low for 5 cycles
        send_frame(8'h55, 1'b0, 1'b0);
        check_flags("ferr", 1'b0, 1'b0, 1'b1);
        check("ferr.busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0);
            check("brk.busy", {31'd0, busy}, 32'd1);
            check_flags("brk", 1'b0, 1'b0, 1'b0);
        end
        send_bit(1'b1);
        check("brk.exit_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1);
        check_flags("3c", 1'b1, 1'b0, 1'b0);
        check("3c.PO", {24'd0, PO}, 32'h3C);
        check("3c.count", {24'd0, count}, 32'd2);

        // Back-to-back 0xFF, 0x00 with no idle gap
        send_frame(8'hFF, 1'b0, 1'b1);
        check_flags("ff", 1'b1, 1'b0, 1'b0);
        check("ff.PO", {24'd0, PO}, 32'hFF);
        send_frame(8'h00, 1'b0, 1'b1);
        check_flags("00", 1'b1, 1'b0, 1'b0);
        check("00.PO", {24'd0, PO}, 32'h00);
        check("b2b.count", {24'd0, count}, 32'd4);
        @(negedge clk);
        #1;
        check("b2b.spacing", v_last - v_prev, 32'd11);

        // Reset after 4 data bits of a frame
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        #1;
        check("mid.rst_count", {24'd0, count}, 32'd0);
        check("mid.rst_busy", {31'd0, busy}, 32'd0);
        check("mid.rst_PO", {24'd0, PO}, 32'h00);
        check_flags("mid.rst", 1'b0, 1'b0, 1'b0);
        SI = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            send_bit(1'b1);
            check_flags("post_rst", 1'b0, 1'b0, 1'b0);
            check("post_rst.busy", {31'd0, busy}, 32'd0);
        end
        send_frame(8'h81, 1'b0, 1'b1);
        check_flags("81", 1'b1, 1'b0, 1'b0);
        check("81.PO", {24'd0, PO}, 32'h81);
        check("81.count", {24'd0, count}, 32'd1);

        // 256 consecutive good frames from reset: counter wraps
        rst = 1'b1;
        SI  = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 256; n++) begin
            logic [7:0] b;
            b = n[7:0];
            send_frame(b, ^b, 1'b1);
            check("wrap.valid", {31'd0, valid}, 32'd1);
            if (n == 254) check("wrap.count255", {24'd0, count}, 32'd255);
        end
        check("wrap.count", {24'd0, count}, 32'd0);
        check("wrap.PO", {24'd0, PO}, 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
